uart_sd_sector_packer: RTL and testbench

UART_SD_SECTOR_PACKER -- requirements
Module: uart_sd_sector_packer

---
 rtl/uart_sd_sector_packer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_sd_sector_packer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sd_sector_packer.sv
// -----------------------------------------------------------------------------
// uart_sd_sector_packer
//
// Packs a UART byte stream into SD-card sectors. It uses two ping-pong banks of
// SECTOR_BYTES/2 16-bit words. One bank fills from rx_valid/rx_data while the
// other bank is handed to the SD write controller. Bytes are stored big-endian:
// the even-index byte goes in the high half of a word and the odd-index byte in
// the low half.
//
// A bank closes in either of two cases:
//   - it holds SECTOR_BYTES bytes, or
//   - flush arrives while it holds at least one byte.
// When a bank closes, its length is recorded. Filling moves to the other bank
// only once that bank is empty. A byte that arrives while both banks are closed
// is dropped, and the sticky overflow flag is set.
//
// Drain handshake (registered outputs):
//   IDLE -> REQ  : a closed bank is waiting to drain; wr_req=1, wr_addr valid
//   REQ  -> XFER : wr_busy seen high; wr_req drops
//   XFER         : each wr_data_req loads the next word into wr_data. Bytes at
//                  or past the recorded length read back as PAD_BYTE. Extra
//                  requests hold the last word.
//   XFER -> DONE : wr_busy falls
//   DONE -> IDLE : frees the bank and bumps wr_addr and sector_cnt (both wrap)
//
// Optional feature, compile macro IDLE_FLUSH_EN:
//   A non-empty, still-open fill bank is flushed automatically once the input
//   has been idle for TIMEOUT_CYC cycles. Without the macro there is no timer.
//
// Parameters:
//   SECTOR_BYTES : bytes per sector (even power of two, 64..4096)
//   START_SECTOR : first sector address after reset
//   PAD_BYTE     : fill value for the unused tail of a flushed sector
//   TIMEOUT_CYC  : idle cycles before auto-flush (IDLE_FLUSH_EN only, >= 2)
//
// Ports:
//   sys_clk      in   clock
//   sys_rst_n    in   asynchronous active-low reset
//   rx_valid     in   one-cycle strobe, rx_data holds a byte
//   rx_data      in   [7:0] received byte
//   flush        in   one-cycle pulse, close the partial fill bank
//   wr_req       out  request to the SD write controller
//   wr_addr      out  [31:0] sector address, valid while wr_req is high
//   wr_busy      in   SD write controller busy
//   wr_data_req  in   one-cycle pulse, present the next word
//   wr_data      out  [15:0] sector data word
//   overflow     out  sticky, a byte was dropped
//   sector_cnt   out  [31:0] sectors fully handed off
// -----------------------------------------------------------------------------
module uart_sd_sector_packer #(
  parameter int          SECTOR_BYTES = 512,
  parameter logic [31:0] START_SECTOR = 32'd1000,
  parameter logic [7:0]  PAD_BYTE     = 8'h00,
  parameter int          TIMEOUT_CYC  = 50_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        flush,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  input  logic        wr_busy,
  input  logic        wr_data_req,
  output logic [15:0] wr_data,
  output logic        overflow,
  output logic [31:0] sector_cnt
);

  localparam int WORDS = SECTOR_BYTES / 2;
  localparam int WA_W  = $clog2(WORDS);
  localparam int LEN_W = $clog2(SECTOR_BYTES) + 1;

  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(SECTOR_BYTES);
  localparam logic [WA_W-1:0]  WA_LAST  = WA_W'(WORDS - 1);

  // Reject configurations that the address arithmetic below cannot handle.
  if (SECTOR_BYTES < 64 || SECTOR_BYTES > 4096 ||
      (SECTOR_BYTES & (SECTOR_BYTES - 1)) != 0) begin : g_bad_sector_bytes
    $error("SECTOR_BYTES must be a power of two in 64..4096");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DONE
  } state_t;

  state_t state;

  // Storage. The high and low byte lanes are separate arrays so that single
  // bytes can be written. The index is {bank, word}.
  logic [7:0] mem_hi [2*WORDS];
  logic [7:0] mem_lo [2*WORDS];

  // Per-bank bookkeeping. A bank is empty when it is not closed and its
  // length is zero. Only the fill bank can hold an open, non-zero length.
  logic [LEN_W-1:0] bank_len [2];
  logic [1:0]       bank_closed;
  logic             fill_bank;
  logic             drain_bank;

  logic             idle_fire;
  logic             flush_any;
  logic             wr_bank;
  logic             wr_open;
  logic [LEN_W-1:0] cur_len;
  logic             byte_ok;
  logic [LEN_W-1:0] next_len;
  logic             close_now;
  logic             bank_free;

  // Idle auto-flush timer
`ifdef IDLE_FLUSH_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  // The close fires one cycle early. This absorbs the FSM's IDLE->REQ step, so
  // wr_req rises exactly TIMEOUT_CYC cycles after the last accepted strobe.
  localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(TIMEOUT_CYC - 2);
  localparam logic [TMR_W-1:0] TMR_HOLD = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] idle_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt <= '0;
    end else if (rx_valid) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TMR_HOLD) begin
      idle_cnt <= idle_cnt + TMR_W'(1);
    end
  end

  // The counter parks at TMR_HOLD, so the timer fires only once per idle gap.
  assign idle_fire = !rx_valid && (idle_cnt == TMR_FIRE);
`else
  assign idle_fire = 1'b0;
`endif

  assign flush_any = flush | idle_fire;

  // Fill-side control. If the fill bank is closed and the other bank is
  // empty, this cycle's byte goes straight into the other bank. That bank
  // also becomes the fill bank.
  assign wr_bank   = (bank_closed[fill_bank] && !bank_closed[~fill_bank]) ?
                     ~fill_bank : fill_bank;
  assign wr_open   = !bank_closed[wr_bank];
  assign cur_len   = bank_len[wr_bank];
  assign byte_ok   = rx_valid && wr_open;
  assign next_len  = cur_len + LEN_W'(byte_ok);
  // A coincident byte counts toward the flushed length. A flush on an empty
  // bank therefore sees next_len == 0 and does nothing.
  assign close_now = wr_open &&
                     ((byte_ok && (next_len == LEN_FULL)) ||
                      (flush_any && (next_len != '0)));
  assign bank_free = (state == S_DONE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fill_bank   <= 1'b0;
      bank_closed <= 2'b00;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      overflow    <= 1'b0;
    end else begin
      fill_bank <= wr_bank;
      if (rx_valid && !wr_open) begin
        overflow <= 1'b1;
      end
      if (wr_open) begin
        bank_len[wr_bank] <= next_len;
        if (close_now) begin
          bank_closed[wr_bank] <= 1'b1;
        end
      end
      // The bank being freed is always closed, so the fill branch above can
      // never select it in the same cycle.
      if (bank_free) begin
        bank_closed[drain_bank] <= 1'b0;
        bank_len[drain_bank]    <= '0;
      end
    end
  end

  // Byte write into the sector storage (data only, no reset)
  always_ff @(posedge sys_clk) begin
    if (byte_ok) begin
      if (!cur_len[0]) begin
        mem_hi[{wr_bank, cur_len[LEN_W-2:1]}] <= rx_data;
      end else begin
        mem_lo[{wr_bank, cur_len[LEN_W-2:1]}] <= rx_data;
      end
    end
  end

  // Drain-side word fetch with tail padding
  logic [WA_W-1:0]  rd_idx;
  logic [WA_W:0]    rd_addr;
  logic [LEN_W-1:0] rd_len;
  logic [LEN_W-1:0] hi_pos;
  logic [LEN_W-1:0] lo_pos;
  logic [15:0]      rd_word;

  assign rd_addr = {drain_bank, rd_idx};
  assign rd_len  = bank_len[drain_bank];
  assign hi_pos  = {1'b0, rd_idx, 1'b0};
  assign lo_pos  = {1'b0, rd_idx, 1'b1};
  assign rd_word = {(hi_pos < rd_len) ? mem_hi[rd_addr] : PAD_BYTE,
                    (lo_pos < rd_len) ? mem_lo[rd_addr] : PAD_BYTE};

  // Drain FSM with registered handshake outputs
  logic busy_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      wr_req     <= 1'b0;
      wr_addr    <= START_SECTOR;
      wr_data    <= 16'h0000;
      sector_cnt <= 32'd0;
      drain_bank <= 1'b0;
      rd_idx     <= '0;
      busy_d     <= 1'b0;
    end else begin
      busy_d <= wr_busy;
      case (state)
        S_IDLE: begin
          if (bank_closed[drain_bank]) begin
            wr_req <= 1'b1;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (wr_busy) begin
            wr_req <= 1'b0;
            rd_idx <= '0;
            state  <= S_XFER;
          end
        end
        S_XFER: begin
          if (wr_data_req) begin
            wr_data <= rd_word;
            // Saturate on the last word so that surplus requests repeat it.
            if (rd_idx != WA_LAST) begin
              rd_idx <= rd_idx + WA_W'(1);
            end
          end
          if (busy_d && !wr_busy) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          wr_addr    <= wr_addr + 32'd1;
          sector_cnt <= sector_cnt + 32'd1;
          drain_bank <= ~drain_bank;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sd_sector_packer.sv
// -----------------------------------------------------------------------------
// tb_uart_sd_sector_packer
//
// Self-checking bench for uart_sd_sector_packer (default sector size, with
// TIMEOUT_CYC=100).
//
// Stimulus tasks record the accepted bytes in a byte model. When a sector
// closes in the model, the padded words and the sector address are pushed to
// scoreboard queues. The SD-controller task pops and compares those queues as
// the DUT hands each sector over.
//
// Compile with IDLE_FLUSH_EN defined to exercise the idle auto-flush.
// -----------------------------------------------------------------------------
module tb_uart_sd_sector_packer;

  localparam int          SECTOR_BYTES = 512;
  localparam int          WORDS        = SECTOR_BYTES / 2;
  localparam logic [31:0] START_SECTOR = 32'd1000;
  localparam logic [7:0]  PAD          = 8'h00;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        flush;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_busy;
  logic        wr_data_req;
  logic [15:0] wr_data;
  logic        overflow;
  logic [31:0] sector_cnt;

  uart_sd_sector_packer #(
    .SECTOR_BYTES (SECTOR_BYTES),
    .START_SECTOR (START_SECTOR),
    .PAD_BYTE     (PAD),
    .TIMEOUT_CYC  (100)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .flush       (flush),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_busy     (wr_busy),
    .wr_data_req (wr_data_req),
    .wr_data     (wr_data),
    .overflow    (overflow),
    .sector_cnt  (sector_cnt)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  int          n_checks;
  int          n_pass;
  logic [7:0]  mbytes[$];
  logic [15:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] exp_addr;
  logic [31:0] exp_cnt;

  initial begin
    #(20 * 95000);
    $display("FAIL watchdog: simulation still running, got no finish want finish");
    $fatal(1);
  end

  // ---------------- stimulus / model helpers ----------------
  task automatic model_reset();
    exp_addr = START_SECTOR;
    exp_cnt  = 32'd0;
    mbytes.delete();
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic apply_reset();
    sys_rst_n   = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    flush       = 1'b0;
    wr_busy     = 1'b0;
    wr_data_req = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    @(negedge sys_clk);
  endtask

  // Called at a negedge and returns at the next negedge, so back-to-back calls
  // present one byte per clock.
  task automatic send_byte(input logic [7:0] b, input logic f);
    rx_valid = 1'b1;
    rx_data  = b;
    flush    = f;
    @(negedge sys_clk);
    rx_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0;
  endtask

  // Close the model's current sector into the scoreboard queues.
  task automatic push_sector();
    logic [7:0] hi;
    logic [7:0] lo;
    for (int w = 0; w < WORDS; w++) begin
      hi = (2*w   < mbytes.size()) ? mbytes[2*w]   : PAD;
      lo = (2*w+1 < mbytes.size()) ? mbytes[2*w+1] : PAD;
      exp_q.push_back({hi, lo});
    end
    mbytes.delete();
    addr_q.push_back(exp_addr);
    exp_addr = exp_addr + 32'd1;
  endtask

  // SD write controller model. It waits for wr_req, checks the address,
  // pulls every word, holds busy for 'hold' cycles in total, and then checks
  // sector_cnt.
  task automatic sd_sector(input string tag, input int hold, input logic extra);
    int          t;
    logic [15:0] e;
    logic [15:0] last;
    logic [31:0] ea;
    t = 0;
    while (wr_req !== 1'b1 && t < 60000) begin
      @(negedge sys_clk);
      t++;
    end
    n_checks++;
    if (wr_req !== 1'b1) begin
      $display("FAIL %s wr_req wait: got %b want 1", tag, wr_req);
      return;
    end
    n_pass++;
    ea = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hxxxx_xxxx;
    n_checks++;
    if (wr_addr !== ea) $display("FAIL %s wr_addr: got %0d want %0d", tag, wr_addr, ea);
    else n_pass++;
    wr_busy = 1'b1;
    @(negedge sys_clk);
    t = 1;
    n_checks++;
    if (wr_req !== 1'b0) $display("FAIL %s wr_req drop: got %b want 0", tag, wr_req);
    else n_pass++;
    last = 16'h0000;
    for (int i = 0; i < WORDS; i++) begin
      wr_data_req = 1'b1;
      @(negedge sys_clk);
      wr_data_req = 1'b0;
      @(negedge sys_clk);
      t += 2;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      last = e;
      n_checks++;
      if (wr_data !== e) $display("FAIL %s word%0d: got %h want %h", tag, i, wr_data, e);
      else n_pass++;
    end
    if (extra) begin
      wr_data_req = 1'b1;
      @(negedge sys_clk);
      wr_data_req = 1'b0;
      @(negedge sys_clk);
      t += 2;
      n_checks++;
      if (wr_data !== last) $display("FAIL %s extra_req_hold: got %h want %h", tag, wr_data, last);
      else n_pass++;
    end
    while (t < hold) begin
      @(negedge sys_clk);
      t++;
    end
    wr_busy = 1'b0;
    repeat (3) @(negedge sys_clk);
    exp_cnt = exp_cnt + 32'd1;
    n_checks++;
    if (sector_cnt !== exp_cnt) $display("FAIL %s sector_cnt: got %0d want %0d", tag, sector_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic expect_no_req(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge sys_clk);
      if (wr_req === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL %s spurious wr_req: got %0d cycles want 0", tag, seen);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (wr_req !== 1'b0) $display("FAIL reset wr_req: got %b want 0", wr_req); else n_pass++;
    n_checks++;
    if (wr_addr !== START_SECTOR) $display("FAIL reset wr_addr: got %0d want %0d", wr_addr, START_SECTOR); else n_pass++;
    n_checks++;
    if (sector_cnt !== 32'd0) $display("FAIL reset sector_cnt: got %0d want 0", sector_cnt); else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL reset overflow: got %b want 0", overflow); else n_pass++;
    n_checks++;
    if (wr_data !== 16'h0000) $display("FAIL reset wr_data: got %h want 0000", wr_data); else n_pass++;
  endtask

  task automatic test_full_sector();
    logic [7:0] b;
    for (int i = 0; i < SECTOR_BYTES; i++) begin
      b = 8'(i);
      send_byte(b, 1'b0);
      mbytes.push_back(b);
    end
    push_sector();
    sd_sector("full", 600, 1'b1);
  endtask

  task automatic test_partial_flush();
    logic [7:0] pat [3];
    pat[0] = 8'hAA;
    pat[1] = 8'hBB;
    pat[2] = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      send_byte(pat[i], 1'b0);
      mbytes.push_back(pat[i]);
    end
    pulse_flush();
    push_sector();
    sd_sector("partial", 600, 1'b0);
  endtask

  task automatic test_coincident_flush();
    send_byte(8'h55, 1'b1);
    mbytes.push_back(8'h55);
    push_sector();
    repeat (2) @(negedge sys_clk);
    pulse_flush();
    sd_sector("coincide", 600, 1'b0);
    expect_no_req("coincide_second_flush", 50);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    fork
      begin
        logic [7:0] b;
        for (int j = 0; j < 3 * SECTOR_BYTES; j++) begin
          b = 8'(j * 7 + 3);
          send_byte(b, 1'b0);
          if (j < 2 * SECTOR_BYTES) mbytes.push_back(b);
          if (j == SECTOR_BYTES - 1 || j == 2 * SECTOR_BYTES - 1) push_sector();
          if (j == 2 * SECTOR_BYTES - 1) begin
            n_checks++;
            if (overflow !== 1'b0) $display("FAIL b2b overflow_early: got %b want 0", overflow);
            else n_pass++;
          end
        end
      end
      begin
        sd_sector("b2b_s0", 20000, 1'b0);
        sd_sector("b2b_s1", 20000, 1'b0);
      end
    join
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL b2b overflow: got %b want 1", overflow); else n_pass++;
    expect_no_req("b2b_dropped", 50);
  endtask

  task automatic test_reset_mid_xfer();
    int t;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    t = 0;
    while (wr_req !== 1'b1 && t < 100) begin
      @(negedge sys_clk);
      t++;
    end
    n_checks++;
    if (wr_req !== 1'b1) $display("FAIL rstx wr_req wait: got %b want 1", wr_req); else n_pass++;
    wr_busy = 1'b1;
    @(negedge sys_clk);
    wr_data_req = 1'b1;
    @(negedge sys_clk);
    wr_data_req = 1'b0;
    n_checks++;
    if (wr_data !== 16'h1122) $display("FAIL rstx pre word0: got %h want 1122", wr_data); else n_pass++;
    #3;
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (wr_req !== 1'b0) $display("FAIL rstx wr_req: got %b want 0", wr_req); else n_pass++;
    n_checks++;
    if (wr_addr !== START_SECTOR) $display("FAIL rstx wr_addr: got %0d want %0d", wr_addr, START_SECTOR); else n_pass++;
    n_checks++;
    if (sector_cnt !== 32'd0) $display("FAIL rstx sector_cnt: got %0d want 0", sector_cnt); else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL rstx overflow: got %b want 0", overflow); else n_pass++;
    n_checks++;
    if (wr_data !== 16'h0000) $display("FAIL rstx wr_data: got %h want 0000", wr_data); else n_pass++;
    wr_busy = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    expect_no_req("rstx_abandoned", 30);
  endtask

  task automatic test_idle_flush();
    int n;
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      b = 8'(8'h30 + i);
      send_byte(b, 1'b0);
      mbytes.push_back(b);
    end
`ifdef IDLE_FLUSH_EN
    n = 0;
    while (wr_req !== 1'b1 && n < 300) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    n_checks++;
    if (n != 100) $display("FAIL idle_flush latency: got %0d cycles want 100", n); else n_pass++;
    @(negedge sys_clk);
`else
    n = 0;
    repeat (300) begin
      @(negedge sys_clk);
      if (wr_req === 1'b1) n++;
    end
    n_checks++;
    if (n != 0) $display("FAIL no_idle_flush wr_req: got %0d cycles want 0", n); else n_pass++;
    pulse_flush();
`endif
    push_sector();
    sd_sector("idle", 600, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    test_reset();
    test_full_sector();
    test_partial_flush();
    test_coincident_flush();
    test_back_to_back();
    test_reset_mid_xfer();
    test_idle_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
